// File: rtl/pes_sipo_pkg.sv
// Shared definitions for the SIPO receive controller.
//   state_e   : receive FSM state encoding
//   DefaultWidth : default data bits per frame
//   cnt_width : width of a counter that can hold 0..width
package pes_sipo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar,
        StStop
    } state_e;

    localparam int unsigned DefaultWidth = 4;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/pes_sipo_shift.sv
// WIDTH-bit serial-in/parallel-out shift register.
// The serial bit enters the MSB and moves toward bit 0, so after WIDTH shifts
// the first bit received sits in bit 0 (LSB-first word).
// Ports:
//   clk      : clock, rising edge
//   shift_en : shift one bit in this cycle
//   b        : serial input bit
//   data     : parallel contents
// No reset: the controller always shifts in a full word before using it.
module pes_sipo_shift
    import pes_sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic             b,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (shift_en) begin
            data <= {b, data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/pes_sipo_rx_ctrl.sv
// Frame-level receive controller for a serial line feeding a SIPO register.
// Frame: start bit (0), WIDTH data bits LSB-first, optional even-parity bit,
// stop bit (1). The completed word is handed off through a one-entry
// valid/ready holding buffer.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   b          : serial line (idles high)
//   en         : receive enable; dropping it mid-frame aborts the frame
//   clr_i      : clears the sticky overrun flag
//   word_o     : held word
//   valid_o    : held word and error flags are valid
//   ready_i    : consumer accepts the held word when valid_o && ready_i
//   par_err_o  : parity mismatch for the held word
//   frm_err_o  : stop bit was 0 for the held word
//   overrun_o  : sticky, a completed frame was dropped (buffer full)
//   busy_o     : a frame is in progress
module pes_sipo_rx_ctrl
    import pes_sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             en,
    input  logic             clr_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             par_err_o,
    output logic             frm_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              par_pend_q, par_pend_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              overrun_q, overrun_d;

    logic              shift_en;
    logic              stop_done;
    logic              load;
    logic [WIDTH-1:0]  sr_data;

    pes_sipo_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .shift_en (shift_en),
        .b        (b),
        .data     (sr_data)
    );

    // Frame sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        par_pend_d = par_pend_q;
        shift_en   = 1'b0;
        stop_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d      = '0;
                par_pend_d = 1'b0;
                if (en && !b) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (!en) begin
                    state_d = StIdle;
                end else begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? StPar : StStop;
                    end
                end
            end
            StPar: begin
                if (!en) begin
                    state_d = StIdle;
                end else begin
                    // Even parity: line bit must equal XOR of the data bits.
                    par_pend_d = b ^ (^sr_data);
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (!en) begin
                    state_d = StIdle;
                end else begin
                    stop_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding buffer and sticky overrun
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        overrun_d = overrun_q;

        // A full buffer being drained this cycle can accept the new frame.
        load = stop_done && (!valid_q || ready_i);

        if (load) begin
            word_d  = sr_data;
            valid_d = 1'b1;
            perr_d  = par_pend_q;
            ferr_d  = !b;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // Setting beats a simultaneous clear.
        if (stop_done && !load) begin
            overrun_d = 1'b1;
        end else if (clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            par_pend_q <= 1'b0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            par_pend_q <= par_pend_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign par_err_o = perr_q;
    assign frm_err_o = ferr_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_pes_sipo_rx_ctrl.sv
// Self-checking bench for pes_sipo_rx_ctrl (WIDTH=4, PARITY_EN=1).
// A frame-level reference model tracks the holding buffer and overrun flag;
// every tick compares the DUT outputs against it.
module tb_pes_sipo_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       b;
    logic       en;
    logic       clr_i;
    logic       ready_i;
    logic [3:0] word_o;
    logic       valid_o;
    logic       par_err_o;
    logic       frm_err_o;
    logic       overrun_o;
    logic       busy_o;

    always #5 clk = ~clk;

    pes_sipo_rx_ctrl #(
        .WIDTH     (4),
        .PARITY_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b         (b),
        .en        (en),
        .clr_i     (clr_i),
        .word_o    (word_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .par_err_o (par_err_o),
        .frm_err_o (frm_err_o),
        .overrun_o (overrun_o),
        .busy_o    (busy_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit         m_valid;
    logic [3:0] m_word;
    bit         m_perr;
    bit         m_ferr;
    bit         m_ovr;

    logic [3:0] delivered[$];

    typedef struct {
        logic [3:0] data;
        bit         flip;
        bit         stop;
        logic [3:0] exp_word;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock: inputs already driven; stop_evt marks the cycle whose
    // line bit is the stop bit of a complete frame (fw/fpe/ffe its content).
    task automatic tick(input bit stop_evt, input logic [3:0] fw, input bit fpe,
                        input bit ffe, input bit exp_busy);
        bit load;
        if (!rst && valid_o && ready_i) delivered.push_back(word_o);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_word = '0; m_perr = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            load = stop_evt && (!m_valid || ready_i);
            if (load) begin
                m_valid = 1; m_word = fw; m_perr = fpe; m_ferr = ffe;
            end else if (m_valid && ready_i) begin
                m_valid = 0;
            end
            if (stop_evt && !load) m_ovr = 1;
            else if (clr_i) m_ovr = 0;
        end
        #1;
        chk("valid", valid_o, m_valid);
        if (m_valid) begin
            chk("word", word_o, m_word);
            chk("par_err", par_err_o, m_perr);
            chk("frm_err", frm_err_o, m_ferr);
        end
        chk("overrun", overrun_o, m_ovr);
        chk("busy", busy_o, exp_busy);
    endtask

    // 0: ready low, 1: ready high, 2: random, 3: high only on the stop cycle
    function automatic logic rdy(input int mode, input bit is_stop);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'($urandom % 2);
            default: return is_stop;
        endcase
    endfunction

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            b = 1'b1; en = 1'b1; ready_i = rdy(rmode, 0);
            tick(0, 4'h0, 0, 0, 0);
        end
    endtask

    // abort_at: data index at which en drops (negative = full frame)
    task automatic send_frame(input logic [3:0] data, input bit flip, input bit stop_bit,
                              input int rmode, input int abort_at);
        bit par;
        par = (^data) ^ flip;
        en = 1'b1; clr_i = 1'b0;
        b = 1'b0; ready_i = rdy(rmode, 0);
        tick(0, 4'h0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            ready_i = rdy(rmode, 0);
            if (i == abort_at) begin
                en = 1'b0; b = 1'($urandom % 2);
                tick(0, 4'h0, 0, 0, 0);
                en = 1'b1; b = 1'b1;
                return;
            end
            b = data[i];
            tick(0, 4'h0, 0, 0, 1);
        end
        b = par; ready_i = rdy(rmode, 0);
        tick(0, 4'h0, 0, 0, 1);
        b = stop_bit; ready_i = rdy(rmode, 1);
        tick(1, data, flip, !stop_bit, 0);
        b = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'hA, 0, 1, 4'hA, 0, 0};
        tbl[1] = '{4'hA, 1, 1, 4'hA, 1, 0};
        tbl[2] = '{4'hA, 0, 0, 4'hA, 0, 1};
        tbl[3] = '{4'h6, 0, 1, 4'h6, 0, 0};
        tbl[4] = '{4'hF, 1, 0, 4'hF, 1, 1};
        tbl[5] = '{4'h1, 0, 1, 4'h1, 0, 0};

        rst = 1'b1; b = 1'b1; en = 1'b0; clr_i = 1'b0; ready_i = 1'b0;
        tick(0, 4'h0, 0, 0, 0);
        tick(0, 4'h0, 0, 0, 0);
        chk("rst_word", word_o, 4'h0);
        chk("rst_perr", par_err_o, 1'b0);
        chk("rst_ferr", frm_err_o, 1'b0);
        rst = 1'b0;

        // Idle line never starts a frame
        idle(20, 0);

        // Table of single frames with ready low, then drain
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].flip, tbl[i].stop, 0, -1);
            chk("tbl_valid", valid_o, 1'b1);
            chk("tbl_word", word_o, tbl[i].exp_word);
            chk("tbl_perr", par_err_o, tbl[i].exp_perr);
            chk("tbl_ferr", frm_err_o, tbl[i].exp_ferr);
            idle(1, 1);
            chk("tbl_drained", valid_o, 1'b0);
        end

        // Overrun: second frame dropped, first word kept
        send_frame(4'hA, 0, 1, 0, -1);
        send_frame(4'h5, 0, 1, 0, -1);
        chk("ovr_word", word_o, 4'hA);
        chk("ovr_flag", overrun_o, 1'b1);
        clr_i = 1'b1;
        idle(1, 0);
        clr_i = 1'b0;
        chk("ovr_cleared", overrun_o, 1'b0);
        idle(1, 1);

        // Back-to-back with ready held high
        delivered.delete();
        send_frame(4'h3, 0, 1, 1, -1);
        send_frame(4'hC, 0, 1, 1, -1);
        idle(1, 1);
        chk("b2b_count", 16'(delivered.size()), 16'd2);
        if (delivered.size() == 2) begin
            chk("b2b_first", delivered[0], 4'h3);
            chk("b2b_second", delivered[1], 4'hC);
        end
        chk("b2b_ovr", overrun_o, 1'b0);

        // Drain and refill on the same cycle
        delivered.delete();
        send_frame(4'h3, 0, 1, 0, -1);
        send_frame(4'hC, 0, 1, 3, -1);
        chk("refill_word", word_o, 4'hC);
        chk("refill_ovr", overrun_o, 1'b0);
        idle(1, 1);
        chk("refill_count", 16'(delivered.size()), 16'd2);
        if (delivered.size() == 2) begin
            chk("refill_first", delivered[0], 4'h3);
            chk("refill_second", delivered[1], 4'hC);
        end

        // Abort by en after two data bits, then a clean frame
        send_frame(4'h9, 0, 1, 0, 2);
        chk("abort_busy", busy_o, 1'b0);
        idle(8, 0);
        chk("abort_novalid", valid_o, 1'b0);
        send_frame(4'h6, 0, 1, 0, -1);
        chk("post_abort_word", word_o, 4'h6);
        idle(1, 1);

        // Reset mid-frame, then a clean frame
        b = 1'b0; en = 1'b1; ready_i = 1'b0;
        tick(0, 4'h0, 0, 0, 1);
        b = 1'b1; tick(0, 4'h0, 0, 0, 1);
        b = 1'b0; tick(0, 4'h0, 0, 0, 1);
        rst = 1'b1; b = 1'b1;
        tick(0, 4'h0, 0, 0, 0);
        rst = 1'b0;
        idle(8, 0);
        chk("rst_novalid", valid_o, 1'b0);
        send_frame(4'h6, 0, 1, 0, -1);
        chk("post_rst_word", word_o, 4'h6);
        idle(1, 1);

        // Randomized frames, gaps, ready, clears and aborts
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom % 3);
            for (int g = 0; g < gap; g++) begin
                b = 1'b1; en = 1'b1; ready_i = rdy(2, 0);
                clr_i = (($urandom % 6) == 0);
                tick(0, 4'h0, 0, 0, 0);
            end
            clr_i = 1'b0;
            send_frame(4'($urandom), (($urandom % 4) == 0), (($urandom % 4) != 0), 2,
                       (($urandom % 8) == 0) ? int'($urandom % 4) : -1);
        end
        idle(3, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pes_sipo_rx_ctrl.md
# pes_sipo_rx_ctrl

Frame-level receive controller that sequences the 4-bit serial-in/parallel-out shift register on the user-project serial input `io_in[0]`. It detects a start bit, enables the shift register for exactly WIDTH data bits, checks an optional even-parity bit and the stop bit, and hands the assembled word to downstream logic through a one-entry valid/ready holding buffer. It sits between the pad input and any consumer of parallel words inside `user_proj_example`.

## Interface
Parameters:
- `WIDTH`, 4: data bits per frame; legal range 2–16.
- `PARITY_EN`, 1: 1 = one even-parity bit follows the data; 0 = no parity bit.

Ports:
- `clk`  input  1  single clock (`wb_clk_i` at top level); all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `b`  input  1  serial line; idles high; sampled once per `clk`.
- `en`  input  1  receive enable.
- `clr_i`  input  1  clears sticky `overrun_o`.
- `word_o`  output  WIDTH  received word; first data bit received is bit 0 (LSB-first).
- `valid_o`  output  1  `word_o`, `par_err_o` and `frm_err_o` are valid.
- `ready_i`  input  1  consumer accepts the word when `valid_o && ready_i`.
- `par_err_o`  output  1  parity mismatch for the held word.
- `frm_err_o`  output  1  stop bit was 0 for the held word.
- `overrun_o`  output  1  sticky: a completed frame was dropped because the buffer was full.
- `busy_o`  output  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PAR, STOP.
- IDLE: if `en && b==0`, the start bit is accepted; go to DATA with bit counter = 0. Otherwise stay in IDLE.
- DATA: shift `b` into the shift register and increment the counter. After WIDTH bits, go to PAR if `PARITY_EN`, else to STOP.
- PAR: compare `b` with the XOR of the data bits (even parity); latch the mismatch. Go to STOP.
- STOP: sample `b`; `frm_err = (b==0)`. Attempt to load the holding buffer, then return to IDLE.
- Buffer load: succeeds if `!valid_o`, or if `valid_o && ready_i` in the same cycle (drain and refill simultaneously; no overrun).
  - On success, load the word and both error flags into the buffer.
  - Otherwise drop the new frame, set `overrun_o`, and leave the held word unchanged.
- `valid_o` clears on `valid_o && ready_i` when no load happens in that cycle.
- `en` deasserted in DATA, PAR or STOP: abort to IDLE next cycle and discard the partial word. The buffer is unaffected.
- `overrun_o` clears on `clr_i` or `rst`. If `clr_i` and a new overrun occur in the same cycle, the set wins.
- Shift register: no reset needed. Bits are only shifted while in DATA and are always fully overwritten before a load.

## Timing
- Reset values: `word_o=0`, `valid_o=0`, `par_err_o=0`, `frm_err_o=0`, `overrun_o=0`, `busy_o=0`; FSM in IDLE, counter = 0.
- `rst` mid-frame: next cycle is IDLE with all outputs at their reset values. The held word is lost.
- With start bit sampled at cycle 0: data bits are sampled at cycles 1..WIDTH, parity at WIDTH+1 (when enabled), stop at WIDTH+1+PARITY_EN.
- `valid_o` rises the cycle after stop is sampled. Latency from start bit = WIDTH+2+PARITY_EN cycles (7 for the defaults).
- Back-to-back frames: a new start bit may be sampled in the cycle immediately after the STOP cycle. There is no idle gap requirement.
- `busy_o` is high in DATA, PAR and STOP, registered from the state.

## Structure
- Shared package `pes_sipo_pkg`:
  - state encoding (typedef for IDLE/DATA/PAR/STOP)
  - default `WIDTH`
  - counter-width function `$clog2(WIDTH+1)`
- One sub-module, `pes_sipo_shift`: a parameterized WIDTH-bit SIPO with shift enable. The serial bit enters the MSB and shifts toward bit 0, so the first data bit ends in bit 0.
- The FSM, parity accumulator, holding buffer and flags live in the top module.

## Test plan
All scenarios use WIDTH=4, PARITY_EN=1.
- Reset, then `en=1`, `b=1` for 20 cycles → `busy_o=0` and `valid_o=0` throughout.
- Line sequence 0,0,1,0,1,0,1 (start, data 0101, parity 0, stop) with `ready_i=0` → `valid_o` rises 7 cycles after the start bit; `word_o=4'hA`, `par_err_o=0`, `frm_err_o=0`.
- Same frame with parity bit 1 → `word_o=4'hA`, `par_err_o=1`. Same frame with stop bit 0 → `frm_err_o=1`.
- With `ready_i=0`, send 0xA then 0x5 back-to-back → `word_o` stays 4'hA and `overrun_o=1`. Pulsing `clr_i` clears `overrun_o`.
- Hold `ready_i=1` while sending 0x3 and 0xC back-to-back → two `valid_o` pulses delivering 4'h3 then 4'hC; `overrun_o` stays 0, including on the simultaneous drain-and-refill cycle.
- Drop `en` after 2 data bits, or assert `rst` mid-frame → IDLE next cycle and no `valid_o`. The following full 0x6 frame is received correctly.
